// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared constants and state type for the multiply/divide unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [5:0] FUNCT_MULT = 6'b011000;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } md_state_e;

endpackage

`default_nettype wire

// File: rtl/mult_div_unit_if.sv
// ============================================================================
// Module   : mult_div_unit_if
// Brief    : Request/result bundle between the control unit and mult_div_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mult_div_unit_if
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
);
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, funct, a, b, input busy, done, hi, lo);
    modport slave  (input start, funct, a, b, output busy, done, hi, lo);
endinterface

`default_nettype wire

// File: rtl/muldiv_negate.sv
// ============================================================================
// Module   : muldiv_negate
// Brief    : Conditional two's-complement negate (combinational).
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);
    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;
endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative signed MULT/DIV, one bit per cycle. Macro MULDIV_DIV_EN
//            enables the restoring divider; without it DIV is ignored.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    mult_div_unit_if.slave        bus
);
    localparam logic [5:0] LAST_CNT = 6'(WIDTH - 1);

    md_state_e        state_q;
    logic [5:0]       cnt_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             sign_a_q, sign_b_q;
    logic [WIDTH:0]   opnd_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;

    logic [WIDTH:0]   abs_a, abs_b;
    logic             accept_mult, accept_div;
    logic [WIDTH+1:0] mul_sum;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] hi_d, lo_d;

    // WIDTH+1-bit magnitudes keep |32'h80000000| representable
    muldiv_negate #(.W(WIDTH+1)) u_abs_a (
        .val_i({bus.a[WIDTH-1], bus.a}), .neg_i(bus.a[WIDTH-1]), .val_o(abs_a));
    muldiv_negate #(.W(WIDTH+1)) u_abs_b (
        .val_i({bus.b[WIDTH-1], bus.b}), .neg_i(bus.b[WIDTH-1]), .val_o(abs_b));

    assign accept_mult = (bus.funct == FUNCT_MULT);

`ifdef MULDIV_DIV_EN
    logic             is_div_q, div0_q;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign accept_div = (bus.funct == FUNCT_DIV);
    assign div_shift  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign div_diff   = {1'b0, div_shift} - {1'b0, opnd_q};

    muldiv_negate #(.W(WIDTH)) u_fix_quo (
        .val_i(quo_q), .neg_i(sign_a_q ^ sign_b_q), .val_o(quo_fix));
    muldiv_negate #(.W(WIDTH)) u_fix_rem (
        .val_i(rem_q[WIDTH-1:0]), .neg_i(sign_a_q), .val_o(rem_fix));
`else
    assign accept_div = 1'b0;
`endif

    muldiv_negate #(.W(2*WIDTH)) u_fix_prod (
        .val_i({rem_q[WIDTH-1:0], quo_q}), .neg_i(sign_a_q ^ sign_b_q), .val_o(prod_fix));

    // One iteration: multiplier bits retire from quo_q LSB, quotient bits enter at LSB
    always_comb begin
        mul_sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opnd_q} : '0);
        rem_d   = mul_sum[WIDTH+1:1];
        quo_d   = {mul_sum[0], quo_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
            if (!div_diff[WIDTH+1]) begin
                rem_d = div_diff[WIDTH:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = div_shift;
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = div0_q ? '1 : quo_fix;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opnd_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
`ifdef MULDIV_DIV_EN
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && (accept_mult || accept_div)) begin
                        state_q  <= ST_CALC;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        sign_a_q <= bus.a[WIDTH-1];
                        sign_b_q <= bus.b[WIDTH-1];
                        rem_q    <= '0;
                        opnd_q   <= accept_div ? abs_b : abs_a;
                        quo_q    <= accept_div ? abs_a[WIDTH-1:0] : abs_b[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
                        is_div_q <= accept_div;
                        div0_q   <= (bus.b == '0);
`endif
                    end
                end
                ST_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Self-checking bench for mult_div_unit; honours MULDIV_DIV_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mult_div_unit;
    import mips_pkg::*;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mult_div_unit_if #(.WIDTH(W)) bus ();
    mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic, result as {hi, lo}
    function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] x,
                                               input logic [31:0] y);
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (f == FUNCT_MULT) return 64'(sx * sy);
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {32'(sx % sy), 32'(sx / sy)};
    endfunction

    function automatic bit op_ok(input logic [5:0] f);
`ifdef MULDIV_DIV_EN
        return (f == FUNCT_MULT) || (f == FUNCT_DIV);
`else
        return (f == FUNCT_MULT);
`endif
    endfunction

    // Timing model: an op accepted at edge N is busy for cycles N+1..N+34 and
    // publishes its result with done during cycle N+34.
    int          cyc = 0;
    int          acc_cyc = 0;
    bit          active = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] pend = '0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            active = 1'b0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
        end else begin
            m_done = 1'b0;
            if (active) begin
                if (cyc == acc_cyc + 33) begin
                    {m_hi, m_lo} = pend;
                    m_done = 1'b1;
                end else if (cyc == acc_cyc + 34) begin
                    active = 1'b0;
                    m_busy = 1'b0;
                end
            end else if (bus.start && op_ok(bus.funct)) begin
                active  = 1'b1;
                acc_cyc = cyc;
                m_busy  = 1'b1;
                pend    = ref_result(bus.funct, bus.a, bus.b);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            check("cycle", {bus.busy, bus.done, bus.hi, bus.lo}, {m_busy, m_done, m_hi, m_lo});
    end

    task automatic pulse(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        bus.start = 1'b1; bus.funct = f; bus.a = x; bus.b = y;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = $urandom; bus.b = $urandom;
    endtask

    // Called right after pulse (cycle N+1); lat counts cycles until done.
    task automatic wait_done(output int lat, output int nbusy);
        lat = 1; nbusy = 0;
        forever begin
            if (bus.busy) nbusy++;
            if (bus.done === 1'b1 || lat >= 60) break;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
        int lat, nb;
        pulse(f, x, y);
        wait_done(lat, nb);
        check({name, " latency"}, 128'(lat), 128'(34));
        check({name, " busy cycles"}, 128'(nb), 128'(34));
        check({name, " hi"}, 128'(bus.hi), 128'(ehi));
        check({name, " lo"}, 128'(bus.lo), 128'(elo));
        @(negedge clk);
        check({name, " idle after"}, 128'({bus.busy, bus.done}), 128'(2'b00));
    endtask

    task automatic run_ignored(input string name, input logic [5:0] f);
        logic [31:0] ohi, olo;
        int nb, nd;
        ohi = bus.hi; olo = bus.lo;
        pulse(f, 32'd12, 32'd3);
        nb = 0; nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy) nb++;
            if (bus.done) nd++;
        end
        check({name, " busy"}, 128'(nb + nd), 128'(0));
        check({name, " hold"}, {64'd0, bus.hi, bus.lo}, {64'd0, ohi, olo});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nd, lat, nb;
        logic [31:0] dhi, dlo;
        bus.start = 1'b0; bus.funct = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        check("reset state", {62'd0, bus.busy, bus.done, bus.hi, bus.lo}, 128'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        run_op("mult 7*6", FUNCT_MULT, 32'd7, 32'd6, 32'd0, 32'd42);
        run_op("mult -3*5", FUNCT_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
`ifdef MULDIV_DIV_EN
        run_op("div -17/5", FUNCT_DIV, 32'hFFFF_FFEF, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_op("div 9/0", FUNCT_DIV, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
        run_op("div min/-1", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op("div -7/0", FUNCT_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
`else
        run_ignored("div disabled", FUNCT_DIV);
`endif

        // Most-negative square, with a second start at N+10 that must be dropped
        pulse(FUNCT_MULT, 32'h8000_0000, 32'h8000_0000);
        repeat (8) @(negedge clk);
        bus.start = 1'b1; bus.funct = FUNCT_MULT; bus.a = 32'd1; bus.b = 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        nd = 0; dhi = '0; dlo = '0;
        repeat (70) begin
            @(negedge clk);
            if (bus.done) begin nd++; dhi = bus.hi; dlo = bus.lo; end
        end
        check("min*min done count", 128'(nd), 128'(1));
        check("min*min result", {64'd0, dhi, dlo}, {64'd0, 32'h4000_0000, 32'd0});

        // Abort mid-calculation; start during reset is ignored
        run_op("mult 5*5", FUNCT_MULT, 32'd5, 32'd5, 32'd0, 32'd25);
`ifdef MULDIV_DIV_EN
        pulse(FUNCT_DIV, 32'd100, 32'd7);
`else
        pulse(FUNCT_MULT, 32'd100, 32'd7);
`endif
        repeat (13) @(negedge clk);
        reset = 1'b1; bus.start = 1'b1; bus.funct = FUNCT_MULT;
        @(negedge clk);
        check("abort state", {62'd0, bus.busy, bus.done, bus.hi, bus.lo}, 128'd0);
        reset = 1'b0; bus.start = 1'b0;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) nd++;
        end
        check("abort no done", 128'(nd), 128'(0));

        run_ignored("bad funct", 6'b100000);
        run_op("mult after abort", FUNCT_MULT, 32'd7, 32'd6, 32'd0, 32'd42);

        // Randomized traffic, including starts while busy and rare resets
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 4))
                0, 1:    bus.funct = FUNCT_MULT;
                2, 3:    bus.funct = FUNCT_DIV;
                default: bus.funct = 6'($urandom);
            endcase
            bus.a = pick();
            bus.b = pick();
            reset = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        bus.start = 1'b0; reset = 1'b0;
        wait_done(lat, nb);
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is required to be supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 start  input  1  request pulse from control unit; sampled only in IDLE.
REQ-005 funct  input  6  operation select: 6'b011000 MULT, 6'b011010 DIV; other codes are ignored.
REQ-006 a  input  WIDTH  rs operand (multiplicand / dividend), two's complement.
REQ-007 b  input  WIDTH  rt operand (multiplier / divisor), two's complement.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  single-cycle completion pulse.
REQ-010 hi  output  WIDTH  HI register (product upper half / remainder).
REQ-011 lo  output  WIDTH  LO register (product lower half / quotient).

Function
REQ-012 States SHALL be IDLE, CALC, FIXUP, DONE.
REQ-013 IDLE->CALC when start=1 and funct is MULT or DIV; latch |a|, |b|, operand signs, and op; clear iteration counter.
REQ-014 IDLE with start=1 and any other funct SHALL remain IDLE with no register change.
REQ-015 CALC SHALL run exactly WIDTH cycles: shift-add multiply (MULT) or restoring divide (DIV), one bit per cycle; 6-bit counter.
REQ-016 CALC->FIXUP when the counter reaches WIDTH-1; FIXUP->DONE unconditionally; DONE->IDLE unconditionally.
REQ-017 FIXUP SHALL apply sign correction and write hi/lo: MULT product negated if sign(a)^sign(b); DIV quotient negated if sign(a)^sign(b), remainder takes sign of a.
REQ-018 Latency: start sampled at edge N -> done=1 during cycle N+34; busy=1 cycles N+1..N+34.
REQ-019 hi/lo SHALL hold prior values until the FIXUP edge, then hold until the next FIXUP or reset.
REQ-020 start asserted while busy=1 SHALL be ignored (not queued).
REQ-021 Divide by zero (b=0): state sequence and latency unchanged; result SHALL be hi=a, lo=32'hFFFFFFFF.
REQ-022 Most-negative cases: 32'h80000000 operands SHALL be handled via WIDTH+1-bit magnitudes; DIV 32'h80000000 / -1 yields lo=32'h80000000, hi=0.
REQ-023 Operands a/b SHALL be captured at start; later changes on a/b SHALL NOT affect the result.

Reset
REQ-024 reset=1 at a clock edge SHALL force IDLE, busy=0, done=0, hi=0, lo=0, counter=0, regardless of state.
REQ-025 Reset mid-CALC SHALL abort the operation with no done pulse; start is ignored during the reset cycle.

Configuration
REQ-026 Macro MULDIV_DIV_EN: defined -> DIV supported as above.
REQ-027 MULDIV_DIV_EN undefined -> divider datapath removed; funct DIV treated as unsupported code (REQ-014); MULT unaffected.

Structure
REQ-028 Shared package mips_pkg SHALL hold funct constants (FUNCT_MULT, FUNCT_DIV), the state enum type, and WIDTH default.
REQ-029 One sub-module is natural: muldiv_negate (conditional two's-complement negate, combinational), instantiated for operand abs and result fixup.

Verification
REQ-030 MULT a=7, b=6, start one cycle -> done at N+34, hi=0, lo=42, busy high 34 cycles.
REQ-031 MULT a=-3 (32'hFFFFFFFD), b=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1.
REQ-032 DIV a=-17, b=5 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFE (-2); DIV a=9, b=0 -> hi=9, lo=32'hFFFFFFFF.
REQ-033 MULT 32'h80000000 * 32'h80000000 -> hi=32'h40000000, lo=0; second start at N+10 ignored, single done.
REQ-034 Reset asserted at N+15 of a DIV -> IDLE next cycle, hi=lo=0, no done; funct=6'b100000 with start -> busy stays 0.
REQ-035 Build without MULDIV_DIV_EN: DIV start -> busy stays 0, hi/lo unchanged; MULT 7*6 still yields lo=42.
